// File: rtl/traffic_intersection_ctrl.sv
// Two-approach (NS/EW) intersection sequencer with demand-driven green rest and all-red clearance.
// Optional pedestrian walk phase is compiled in when PED_WALK_EN is defined.
module traffic_intersection_ctrl #(
    parameter int GREEN_T  = 10,
    parameter int YELLOW_T = 5,
    parameter int ALLRED_T = 2,
    parameter int WALK_T   = 8,
    parameter int CW       = 4
) (
    input  logic          in_clk,
    input  logic          in_rst_n,
    input  logic          in_tick,
    input  logic          in_srt,
    input  logic          in_stop,
    input  logic          in_ns_req,
    input  logic          in_ew_req,
    input  logic          in_ped_btn,
    output logic          o_ns_green,
    output logic          o_ns_yellow,
    output logic          o_ns_red,
    output logic          o_ew_green,
    output logic          o_ew_yellow,
    output logic          o_ew_red,
    output logic          o_walk,
    output logic [2:0]    o_state,
    output logic [CW-1:0] o_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NSG  = 3'd1,
        S_NSY  = 3'd2,
        S_AR1  = 3'd3,
        S_EWG  = 3'd4,
        S_EWY  = 3'd5,
        S_AR2  = 3'd6,
        S_WALK = 3'd7
    } state_t;

    localparam logic [CW-1:0] G_LAST = CW'(GREEN_T - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] A_LAST = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] W_LAST = CW'(WALK_T - 1);

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic [CW-1:0] dur_last;
    logic          expired;
    logic          stop_pend;
    logic          ped_pend;
    logic          ret_ns, ret_ns_nx;

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state  <= S_IDLE;
            count  <= '0;
            ret_ns <= 1'b0;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            ret_ns <= ret_ns_nx;
        end
    end

    // Stop is sticky until the sequence actually lands in IDLE.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n)
            stop_pend <= 1'b0;
        else if (state_nx == S_IDLE && state != S_IDLE)
            stop_pend <= 1'b0;
        else if (in_stop && state != S_IDLE)
            stop_pend <= 1'b1;
    end

`ifdef PED_WALK_EN
    // A press on the WALK entry cycle must survive, so set takes precedence.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n)
            ped_pend <= 1'b0;
        else if (in_ped_btn && state != S_IDLE)
            ped_pend <= 1'b1;
        else if (state_nx == S_WALK && state != S_WALK)
            ped_pend <= 1'b0;
    end
    assign o_walk = (state == S_WALK);
`else
    logic unused_ped_btn;
    assign unused_ped_btn = in_ped_btn;
    assign ped_pend       = 1'b0;
    assign o_walk         = 1'b0;
`endif

    always_comb begin
        dur_last = '0;
        case (state)
            S_NSG, S_EWG: dur_last = G_LAST;
            S_NSY, S_EWY: dur_last = Y_LAST;
            S_AR1, S_AR2: dur_last = A_LAST;
            S_WALK:       dur_last = W_LAST;
            default:      dur_last = '0;
        endcase
    end

    assign expired = in_tick && (count == dur_last);

    always_comb begin
        state_nx  = state;
        ret_ns_nx = ret_ns;
        case (state)
            S_IDLE: if (in_srt) state_nx = S_NSG;
            S_NSG:  if (expired && (in_ew_req || ped_pend)) state_nx = S_NSY;
            S_NSY:  if (expired) state_nx = S_AR1;
            S_AR1: begin
                if (expired) begin
                    if (stop_pend) begin
                        state_nx = S_IDLE;
                    end else if (ped_pend) begin
                        state_nx  = S_WALK;
                        ret_ns_nx = 1'b0;
                    end else begin
                        state_nx = S_EWG;
                    end
                end
            end
            S_EWG:  if (expired && (in_ns_req || ped_pend)) state_nx = S_EWY;
            S_EWY:  if (expired) state_nx = S_AR2;
            S_AR2: begin
                if (expired) begin
                    if (stop_pend) begin
                        state_nx = S_IDLE;
                    end else if (ped_pend) begin
                        state_nx  = S_WALK;
                        ret_ns_nx = 1'b1;
                    end else begin
                        state_nx = S_NSG;
                    end
                end
            end
            S_WALK: if (expired) state_nx = ret_ns ? S_NSG : S_EWG;
            default: state_nx = S_IDLE;
        endcase
    end

    // Holding at dur_last without a state change is the green-rest saturation.
    always_comb begin
        count_nx = count;
        if (state_nx != state)
            count_nx = '0;
        else if (state != S_IDLE && in_tick && count != dur_last)
            count_nx = count + CW'(1);
    end

    always_comb begin
        o_ns_green  = 1'b0;
        o_ns_yellow = 1'b0;
        o_ns_red    = 1'b1;
        o_ew_green  = 1'b0;
        o_ew_yellow = 1'b0;
        o_ew_red    = 1'b1;
        case (state)
            S_NSG: begin o_ns_green  = 1'b1; o_ns_red = 1'b0; end
            S_NSY: begin o_ns_yellow = 1'b1; o_ns_red = 1'b0; end
            S_EWG: begin o_ew_green  = 1'b1; o_ew_red = 1'b0; end
            S_EWY: begin o_ew_yellow = 1'b1; o_ew_red = 1'b0; end
            default: ;
        endcase
    end

    assign o_state = state;
    assign o_count = count;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench for traffic_intersection_ctrl: each state change is popped from exp_q
// and checked for state code, lamp pattern and dwell (cycles spent in the previous state).
module tb_traffic_intersection_ctrl;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_NSG = 3'd1, ST_NSY = 3'd2, ST_AR1 = 3'd3;
    localparam logic [2:0] ST_EWG  = 3'd4, ST_EWY = 3'd5, ST_AR2 = 3'd6, ST_WALK = 3'd7;

    logic       clk, rst_n, tick, srt, stop, ns_req, ew_req, ped_btn;
    logic       ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk;
    logic [2:0] state;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    // packet: {state[2:0], lamps[6:0], dwell[7:0]}; dwell 0 means "do not check dwell"
    logic [17:0] exp_q[$];
    logic [17:0] exp_pkt, act_pkt;
    logic [2:0]  prev_state = 3'd0;
    logic [7:0]  dwell = 8'd0;
    logic        mon_en = 1'b0;

    traffic_intersection_ctrl #(
        .GREEN_T(10), .YELLOW_T(5), .ALLRED_T(2), .WALK_T(8), .CW(4)
    ) dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_tick(tick), .in_srt(srt), .in_stop(stop),
        .in_ns_req(ns_req), .in_ew_req(ew_req), .in_ped_btn(ped_btn),
        .o_ns_green(ns_green), .o_ns_yellow(ns_yellow), .o_ns_red(ns_red),
        .o_ew_green(ew_green), .o_ew_yellow(ew_yellow), .o_ew_red(ew_red),
        .o_walk(walk), .o_state(state), .o_count(count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lamp order: ns_g ns_y ns_r ew_g ew_y ew_r walk
    function automatic logic [6:0] lamp_model(input logic [2:0] s);
        case (s)
            ST_NSG:  return 7'b1000010;
            ST_NSY:  return 7'b0100010;
            ST_EWG:  return 7'b0011000;
            ST_EWY:  return 7'b0010100;
            ST_WALK: return 7'b0010011;
            default: return 7'b0010010;
        endcase
    endfunction

    function automatic logic [6:0] lamps_now();
        return {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk};
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] s, input int d);
        exp_q.push_back({s, lamp_model(s), 8'(d)});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state !== s && n < budget) begin
            step();
            n++;
        end
        if (state !== s) begin
            checks++;
            errors++;
            $display("FAIL wait_state: actual=%0d expected=%0d (timeout)", state, s);
        end
    endtask

    task automatic pulse_srt();
        srt = 1'b1;
        step();
        srt = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (state !== prev_state) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL transition: actual state=%0d expected=none", state);
                end else begin
                    exp_pkt = exp_q.pop_front();
                    act_pkt = {state, lamps_now(), (exp_pkt[7:0] == 8'd0) ? 8'd0 : dwell};
                    if (act_pkt !== exp_pkt) begin
                        errors++;
                        $display("FAIL transition: actual st=%0d lamps=%b dwell=%0d expected st=%0d lamps=%b dwell=%0d",
                                 act_pkt[17:15], act_pkt[14:8], act_pkt[7:0],
                                 exp_pkt[17:15], exp_pkt[14:8], exp_pkt[7:0]);
                    end
                end
                prev_state = state;
                dwell      = 8'd1;
            end else begin
                dwell = dwell + 8'd1;
            end
        end
    end

    initial begin
        rst_n = 1'b0; tick = 1'b1; srt = 1'b0; stop = 1'b0;
        ns_req = 1'b0; ew_req = 1'b0; ped_btn = 1'b0;
        repeat (3) step();
        check("reset_state", 32'(state), 32'(ST_IDLE));
        check("reset_count", 32'(count), 32'd0);
        check("reset_lamps", 32'(lamps_now()), 32'(7'b0010010));
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // full rotation with demand on both approaches
        ns_req = 1'b1; ew_req = 1'b1;
        push_exp(ST_NSG, 0);
        pulse_srt();
        push_exp(ST_NSY, 10); push_exp(ST_AR1, 5); push_exp(ST_EWG, 2);
        push_exp(ST_EWY, 10); push_exp(ST_AR2, 5); push_exp(ST_NSG, 2);
        wait_state(ST_AR2, 100);
        wait_state(ST_NSG, 100);

        // green rest: no EW demand holds NSG with count saturated
        ew_req = 1'b0;
        repeat (18) step();
        check("rest_state", 32'(state), 32'(ST_NSG));
        check("rest_count", 32'(count), 32'd9);
        push_exp(ST_NSY, 19); push_exp(ST_AR1, 5); push_exp(ST_EWG, 2);
        push_exp(ST_EWY, 10); push_exp(ST_AR2, 5); push_exp(ST_NSG, 2);
        ew_req = 1'b1;
        wait_state(ST_AR2, 100);
        wait_state(ST_NSG, 100);

`ifdef PED_WALK_EN
        // button during NSG inserts WALK after AR1, then returns to EWG with request consumed
        ped_btn = 1'b1;
        step();
        ped_btn = 1'b0;
        push_exp(ST_NSY, 10); push_exp(ST_AR1, 5); push_exp(ST_WALK, 2);
        push_exp(ST_EWG, 8);  push_exp(ST_EWY, 10); push_exp(ST_AR2, 5); push_exp(ST_NSG, 2);
        wait_state(ST_AR2, 100);
        wait_state(ST_NSG, 100);
`else
        // button is ignored: without EW demand NSG keeps resting, no walk lamp
        ped_btn = 1'b1; ew_req = 1'b0;
        step();
        ped_btn = 1'b0;
        repeat (17) step();
        check("noped_state", 32'(state), 32'(ST_NSG));
        check("noped_count", 32'(count), 32'd9);
        check("noped_walk", 32'(walk), 32'd0);
        push_exp(ST_NSY, 19); push_exp(ST_AR1, 5); push_exp(ST_EWG, 2);
        push_exp(ST_EWY, 10); push_exp(ST_AR2, 5); push_exp(ST_NSG, 2);
        ew_req = 1'b1;
        wait_state(ST_AR2, 100);
        wait_state(ST_NSG, 100);
`endif

        // stop during EWG finishes the EW phase then parks in IDLE
        push_exp(ST_NSY, 10); push_exp(ST_AR1, 5); push_exp(ST_EWG, 2);
        push_exp(ST_EWY, 10); push_exp(ST_AR2, 5); push_exp(ST_IDLE, 2);
        wait_state(ST_EWG, 100);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_state(ST_IDLE, 100);
        check("stop_lamps", 32'(lamps_now()), 32'(7'b0010010));
        repeat (3) step();
        check("idle_count", 32'(count), 32'd0);
        check("idle_hold", 32'(state), 32'(ST_IDLE));
        push_exp(ST_NSG, 0);
        pulse_srt();
        wait_state(ST_NSG, 20);

        // mid-EWY reset at count 3
        push_exp(ST_NSY, 10); push_exp(ST_AR1, 5); push_exp(ST_EWG, 2); push_exp(ST_EWY, 10);
        wait_state(ST_EWY, 100);
        repeat (3) step();
        check("ewy_count", 32'(count), 32'd3);
        push_exp(ST_IDLE, 4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midreset_state", 32'(state), 32'(ST_IDLE));
        check("midreset_count", 32'(count), 32'd0);

        // tick gating freezes NSG; srt while running has no effect
        push_exp(ST_NSG, 0);
        pulse_srt();
        wait_state(ST_NSG, 5);
        repeat (3) step();
        tick = 1'b0;
        srt  = 1'b1;
        step();
        srt  = 1'b0;
        repeat (4) step();
        check("freeze_state", 32'(state), 32'(ST_NSG));
        check("freeze_count", 32'(count), 32'd3);
        push_exp(ST_NSY, 15); push_exp(ST_AR1, 5); push_exp(ST_EWG, 2);
        tick = 1'b1;
        wait_state(ST_EWG, 100);
        repeat (3) step();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
